// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants.
package fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO with flush; push is accepted when full only alongside a pop.
module fetch_queue #(
  parameter  int unsigned WIDTH = 64,
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (cnt == '0);
  assign full    = (cnt == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      cnt <= cnt + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage carries no reset; validity is tracked by cnt alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];
  assign count    = cnt;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited requests to imem, in-order response queue to decode,
// redirect flush with draining of responses that belong to the abandoned path.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned     FQ_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [XLEN-1:0] dec_pc,
  output logic [XLEN-1:0] dec_inst
);

  localparam int unsigned CNT_W = $clog2(FQ_DEPTH + 1);
  localparam int unsigned SUM_W = ((CNT_W > 2) ? CNT_W : 2) + 1;

  fetch_state_e    state_q, state_d;
  logic [1:0]      outstanding_q;
  logic [1:0]      drop_cnt_q, drop_cnt_d;
  logic [XLEN-1:0] pc_q;

  logic            credit_ok;
  logic            req_fire;
  logic            resp_fire;
  logic            fq_push;
  logic            fq_pop;
  logic            pcq_pop;
  fetch_entry_t    fq_in;
  fetch_entry_t    fq_head;
  logic [CNT_W-1:0] fq_count;
  logic            fq_empty;
  logic            fq_full;
  logic [XLEN-1:0] resp_pc;
  logic [CNT_W-1:0] pcq_count;
  logic            pcq_empty;
  logic            pcq_full;
  logic            status_unused;

  assign credit_ok = (SUM_W'(outstanding_q) + SUM_W'(fq_count)) < SUM_W'(FQ_DEPTH);

  assign imem_req_valid = !rst && (state_q == RUN) && credit_ok && !redirect_valid;
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign resp_fire      = imem_resp_valid;

  // Only on-path responses enter the queue; the PC FIFO pairs each one with its address.
  assign fq_push = resp_fire && (state_q == RUN) && !redirect_valid;
  assign pcq_pop = resp_fire && (state_q == RUN) && !pcq_empty;
  assign fq_in   = '{pc: resp_pc, inst: imem_resp_data};

  assign dec_valid = !rst && !fq_empty;
  assign fq_pop    = dec_valid && dec_ready;
  assign dec_pc    = fq_head.pc;
  assign dec_inst  = fq_head.inst;

  assign status_unused = ^{pcq_count, pcq_full, fq_full};

  fetch_queue #(
    .WIDTH (ENTRY_W),
    .DEPTH (FQ_DEPTH)
  ) u_inst_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (fq_push),
    .push_data (fq_in),
    .pop       (fq_pop),
    .pop_data  (fq_head),
    .count     (fq_count),
    .empty     (fq_empty),
    .full      (fq_full)
  );

  fetch_queue #(
    .WIDTH (XLEN),
    .DEPTH (FQ_DEPTH)
  ) u_pc_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (req_fire),
    .push_data (pc_q),
    .pop       (pcq_pop),
    .pop_data  (resp_pc),
    .count     (pcq_count),
    .empty     (pcq_empty),
    .full      (pcq_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      drop_cnt_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Redirect outranks draining; a response landing in the redirect cycle is already gone.
  always_comb begin
    state_d    = state_q;
    drop_cnt_d = drop_cnt_q;
    if (redirect_valid) begin
      drop_cnt_d = (resp_fire && (outstanding_q != 2'd0)) ? outstanding_q - 2'd1 : outstanding_q;
      state_d    = (drop_cnt_d != 2'd0) ? DRAIN : RUN;
    end else begin
      case (state_q)
        DRAIN: begin
          if (drop_cnt_q == 2'd0) begin
            state_d = RUN;
          end else if (resp_fire) begin
            drop_cnt_d = drop_cnt_q - 2'd1;
            if (drop_cnt_q == 2'd1) state_d = RUN;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      outstanding_q <= 2'd0;
    end else begin
      if (redirect_valid) begin
        pc_q <= {redirect_pc[XLEN-1:2], 2'b00};
      end else if (req_fire) begin
        pc_q <= pc_q + XLEN'(4);
      end
      case ({req_fire, resp_fire})
        2'b10:   outstanding_q <= outstanding_q + 2'd1;
        2'b01:   if (outstanding_q != 2'd0) outstanding_q <= outstanding_q - 2'd1;
        default: ;
      endcase
    end
  end

endmodule
